matrix_controller: RTL and testbench
====================================

// Module: matrix_controller
// PURPOSE
//  Main instruction decoder for the single-issue MIPS-subset datapath. Decodes the
//  6-bit opcode and 6-bit function field into datapath control strobes and a 4-bit
//  ALU operation code. Sits between instruction fetch/register and datapath muxes.
//  Outputs are registered: one clock of latency.
// PARAMETERS
//  none
// PORTS
//  clk       in   1  system clock, rising-edge active
//  rst       in   1  reset, asynchronous, active-high
//  op        in   6  instruction opcode [31:26]
//  fcn       in   6  instruction function field [5:0]
//  ALUSrc    out  1  1 = ALU B operand from extended immediate; 0 = from rt
//  ALUSrc2   out  1  1 = ALU shift amount from shamt field (sll/srl/rotr)
//  RegSl     out  1  1 = immediate zero-extended (ori); 0 = sign-extended
//  RegDst    out  1  1 = write register rd; 0 = write register rt
//  RegWrite  out  1  register-file write enable
//  ALUOp     out  4  ALU operation code (table below)
//  MemRead   out  1  data-memory read enable
//  MemWrite  out  1  data-memory write enable
//  MemtoReg  out  1  1 = writeback data from memory; 0 = from ALU
//  Brnch     out  1  branch-on-not-equal request
// BEHAVIOUR
//  - Single clock; rst asynchronous active-high. While rst=1 all outputs = 0.
//  - Combinational decode of (op,fcn) captured into output registers on each rising
//    clk edge; outputs reflect inputs sampled at previous edge (latency 1 cycle).
//  - ALUOp codes: ADD=0000 SUB=0001 AND=0010 OR=0011 SLT=0100 SLL=0101 SRL=0110
//    ROTR=0111 CLO=1000 CLZ=1001 MUL=1010; 1011-1111 unused, never produced.
//  - Decode table (unlisted signals = 0):
//    op=000000 (R-type): RegDst=1 RegWrite=1; fcn 100000 ADD, 100010 SUB,
//      100100 AND, 100101 OR, 101010 SLT; fcn 000000 SLL, 000010 SRL,
//      000110 ROTR with ALUSrc2=1 for these three.
//    op=011100 (SPECIAL2): RegDst=1 RegWrite=1; fcn 100001 CLO, 100000 CLZ,
//      000010 MUL.
//    op=001000 addi: ALUSrc=1 RegWrite=1 ALUOp=ADD (fcn ignored).
//    op=001101 ori : ALUSrc=1 RegSl=1 RegWrite=1 ALUOp=OR.
//    op=100011 lw  : ALUSrc=1 RegWrite=1 MemRead=1 MemtoReg=1 ALUOp=ADD.
//    op=101011 sw  : ALUSrc=1 MemWrite=1 ALUOp=ADD.
//    op=000101 bne : Brnch=1 ALUOp=SUB.
//  - fcn is ignored for all I-type opcodes.
//  - Unsupported op, or unsupported fcn under op 000000/011100: all outputs 0
//    (behaves as NOP; no write, no memory access, no branch).
//  - MemRead and MemWrite never both 1; Brnch never with RegWrite.
//  - X/Z on op or fcn: treat as unsupported (all-zero decode).
//  - No internal state other than output registers; back-to-back changing
//    instructions each decode independently every cycle.
// TESTING
//  - Reset: assert rst mid-cycle with op=100011 loaded -> all outputs 0
//    immediately; release, next edge -> lw decode appears.
//  - R-type sweep: op=000000, fcn 100000/100010/100100/100101/101010 -> ALUOp
//    0000/0001/0010/0011/0100, RegDst=1 RegWrite=1, ALUSrc2=0, one cycle later.
//  - Shifts: fcn 000000/000010/000110 -> ALUOp 0101/0110/0111 with ALUSrc2=1;
//    then op=011100 fcn=000010 -> ALUOp=1010 ALUSrc2=0 (switch back clean).
//  - SPECIAL2: fcn 100001 -> 1000, 100000 -> 1001; RegDst=1 RegWrite=1.
//  - I-type: addi -> ALUSrc=1 RegWrite=1 ALUOp=0000; ori -> ALUSrc=1 RegSl=1
//    ALUOp=0011; lw -> MemRead=MemtoReg=1; sw -> MemWrite=1 RegWrite=0;
//    bne -> Brnch=1 ALUOp=0001, all with fcn=100010.
//  - Illegal: op=111111 or op=000000 fcn=111111 -> all outputs 0.

Source files
------------

// File: rtl/matrix_controller_if.sv
// Instruction-field and control-strobe bundle between the fetch/register stage
// and the main decoder. The decoder takes the slave side.
interface matrix_controller_if;
  logic [5:0] op;
  logic [5:0] fcn;
  logic       ALUSrc;
  logic       ALUSrc2;
  logic       RegSl;
  logic       RegDst;
  logic       RegWrite;
  logic [3:0] ALUOp;
  logic       MemRead;
  logic       MemWrite;
  logic       MemtoReg;
  logic       Brnch;

  modport master (
    output op, fcn,
    input  ALUSrc, ALUSrc2, RegSl, RegDst, RegWrite, ALUOp,
    input  MemRead, MemWrite, MemtoReg, Brnch
  );

  modport slave (
    input  op, fcn,
    output ALUSrc, ALUSrc2, RegSl, RegDst, RegWrite, ALUOp,
    output MemRead, MemWrite, MemtoReg, Brnch
  );
endinterface

// File: rtl/matrix_controller.sv
// Main instruction decoder for the MIPS-subset datapath: (op, fcn) -> registered
// control strobes and 4-bit ALU operation, one cycle of latency.
module matrix_controller (
  input logic              clk,
  input logic              rst,
  matrix_controller_if.slave bus
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_SPEC2 = 6'b011100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_ROTR = 6'b000110;
  localparam logic [5:0] FN_CLO  = 6'b100001;
  localparam logic [5:0] FN_CLZ  = 6'b100000;
  localparam logic [5:0] FN_MUL  = 6'b000010;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_SLT  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_ROTR = 4'b0111;
  localparam logic [3:0] ALU_CLO  = 4'b1000;
  localparam logic [3:0] ALU_CLZ  = 4'b1001;
  localparam logic [3:0] ALU_MUL  = 4'b1010;

  logic       alu_src_d,   alu_src_q;
  logic       alu_src2_d,  alu_src2_q;
  logic       reg_sl_d,    reg_sl_q;
  logic       reg_dst_d,   reg_dst_q;
  logic       reg_write_d, reg_write_q;
  logic [3:0] alu_op_d,    alu_op_q;
  logic       mem_read_d,  mem_read_q;
  logic       mem_write_d, mem_write_q;
  logic       mem_to_reg_d, mem_to_reg_q;
  logic       brnch_d,     brnch_q;
  logic       legal;

  always_comb begin
    alu_src_d    = 1'b0;
    alu_src2_d   = 1'b0;
    reg_sl_d     = 1'b0;
    reg_dst_d    = 1'b0;
    reg_write_d  = 1'b0;
    alu_op_d     = '0;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    mem_to_reg_d = 1'b0;
    brnch_d      = 1'b0;
    legal        = 1'b1;

    case (bus.op)
      OP_RTYPE: begin
        reg_dst_d   = 1'b1;
        reg_write_d = 1'b1;
        case (bus.fcn)
          FN_ADD:  alu_op_d = ALU_ADD;
          FN_SUB:  alu_op_d = ALU_SUB;
          FN_AND:  alu_op_d = ALU_AND;
          FN_OR:   alu_op_d = ALU_OR;
          FN_SLT:  alu_op_d = ALU_SLT;
          FN_SLL:  begin alu_op_d = ALU_SLL;  alu_src2_d = 1'b1; end
          FN_SRL:  begin alu_op_d = ALU_SRL;  alu_src2_d = 1'b1; end
          FN_ROTR: begin alu_op_d = ALU_ROTR; alu_src2_d = 1'b1; end
          default: legal = 1'b0;
        endcase
      end
      OP_SPEC2: begin
        reg_dst_d   = 1'b1;
        reg_write_d = 1'b1;
        case (bus.fcn)
          FN_CLO:  alu_op_d = ALU_CLO;
          FN_CLZ:  alu_op_d = ALU_CLZ;
          FN_MUL:  alu_op_d = ALU_MUL;
          default: legal = 1'b0;
        endcase
      end
      OP_ADDI: begin
        alu_src_d   = 1'b1;
        reg_write_d = 1'b1;
        alu_op_d    = ALU_ADD;
      end
      OP_ORI: begin
        alu_src_d   = 1'b1;
        reg_sl_d    = 1'b1;
        reg_write_d = 1'b1;
        alu_op_d    = ALU_OR;
      end
      OP_LW: begin
        alu_src_d    = 1'b1;
        reg_write_d  = 1'b1;
        mem_read_d   = 1'b1;
        mem_to_reg_d = 1'b1;
        alu_op_d     = ALU_ADD;
      end
      OP_SW: begin
        alu_src_d   = 1'b1;
        mem_write_d = 1'b1;
        alu_op_d    = ALU_ADD;
      end
      OP_BNE: begin
        brnch_d  = 1'b1;
        alu_op_d = ALU_SUB;
      end
      default: legal = 1'b0;
    endcase

    // Unsupported encodings (including X/Z fields, which match no case item)
    // collapse to a full NOP so no partial strobes leak through.
    if (!legal) begin
      alu_src_d    = 1'b0;
      alu_src2_d   = 1'b0;
      reg_sl_d     = 1'b0;
      reg_dst_d    = 1'b0;
      reg_write_d  = 1'b0;
      alu_op_d     = '0;
      mem_read_d   = 1'b0;
      mem_write_d  = 1'b0;
      mem_to_reg_d = 1'b0;
      brnch_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_src_q    <= 1'b0;
      alu_src2_q   <= 1'b0;
      reg_sl_q     <= 1'b0;
      reg_dst_q    <= 1'b0;
      reg_write_q  <= 1'b0;
      alu_op_q     <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      brnch_q      <= 1'b0;
    end else begin
      alu_src_q    <= alu_src_d;
      alu_src2_q   <= alu_src2_d;
      reg_sl_q     <= reg_sl_d;
      reg_dst_q    <= reg_dst_d;
      reg_write_q  <= reg_write_d;
      alu_op_q     <= alu_op_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      brnch_q      <= brnch_d;
    end
  end

  assign bus.ALUSrc   = alu_src_q;
  assign bus.ALUSrc2  = alu_src2_q;
  assign bus.RegSl    = reg_sl_q;
  assign bus.RegDst   = reg_dst_q;
  assign bus.RegWrite = reg_write_q;
  assign bus.ALUOp    = alu_op_q;
  assign bus.MemRead  = mem_read_q;
  assign bus.MemWrite = mem_write_q;
  assign bus.MemtoReg = mem_to_reg_q;
  assign bus.Brnch    = brnch_q;

endmodule

// File: tb/tb_matrix_controller.sv
// Scoreboard bench for matrix_controller: directed instructions push hand-decoded
// control words; a negedge monitor pops and compares one word per cycle.
module tb_matrix_controller;

  logic clk;
  logic rst;

  matrix_controller_if bus ();

  matrix_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [12:0] w;
    string       name;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  // {ALUSrc, ALUSrc2, RegSl, RegDst, RegWrite, ALUOp[3:0], MemRead, MemWrite, MemtoReg, Brnch}
  function automatic logic [12:0] e(input bit as, input bit as2, input bit sl,
                                    input bit rd, input bit rw, input logic [3:0] aop,
                                    input bit mr, input bit mw, input bit m2r, input bit br);
    return {as, as2, sl, rd, rw, aop, mr, mw, m2r, br};
  endfunction

  function automatic logic [12:0] act();
    return {bus.ALUSrc, bus.ALUSrc2, bus.RegSl, bus.RegDst, bus.RegWrite, bus.ALUOp,
            bus.MemRead, bus.MemWrite, bus.MemtoReg, bus.Brnch};
  endfunction

  task automatic check(input string name, input logic [12:0] got, input logic [12:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, got, want);
    end
  endtask

  task automatic issue(input logic [5:0] op, input logic [5:0] fcn,
                       input logic [12:0] w, input string name);
    exp_t it;
    @(negedge clk);
    #1;
    bus.op  = op;
    bus.fcn = fcn;
    it.w    = w;
    it.name = name;
    q.push_back(it);
  endtask

  always @(negedge clk) begin
    exp_t it;
    if (!rst && q.size() > 0) begin
      it = q.pop_front();
      check(it.name, act(), it.w);
    end
  end

  initial begin
    exp_t it;
    int   waited;
    rst     = 1'b1;
    bus.op  = 6'b100011;
    bus.fcn = 6'b000000;
    repeat (2) @(negedge clk);
    check("reset_state", act(), '0);
    #1 rst = 1'b0;

    // Async reset mid-cycle with lw loaded, then release.
    issue(6'b100011, 6'b000000, e(1,0,0,0,1,4'b0000,1,0,1,0), "lw_pre_reset");
    @(negedge clk);
    #1 rst = 1'b1;
    #1 check("rst_async_clear", act(), '0);
    @(negedge clk);
    #1 rst = 1'b0;
    it.w = e(1,0,0,0,1,4'b0000,1,0,1,0);
    it.name = "rst_release_lw";
    q.push_back(it);

    // R-type
    issue(6'b000000, 6'b100000, e(0,0,0,1,1,4'b0000,0,0,0,0), "r_add");
    issue(6'b000000, 6'b100010, e(0,0,0,1,1,4'b0001,0,0,0,0), "r_sub");
    issue(6'b000000, 6'b100100, e(0,0,0,1,1,4'b0010,0,0,0,0), "r_and");
    issue(6'b000000, 6'b100101, e(0,0,0,1,1,4'b0011,0,0,0,0), "r_or");
    issue(6'b000000, 6'b101010, e(0,0,0,1,1,4'b0100,0,0,0,0), "r_slt");
    // Shifts, then a clean switch back to MUL
    issue(6'b000000, 6'b000000, e(0,1,0,1,1,4'b0101,0,0,0,0), "r_sll");
    issue(6'b000000, 6'b000010, e(0,1,0,1,1,4'b0110,0,0,0,0), "r_srl");
    issue(6'b000000, 6'b000110, e(0,1,0,1,1,4'b0111,0,0,0,0), "r_rotr");
    issue(6'b011100, 6'b000010, e(0,0,0,1,1,4'b1010,0,0,0,0), "s2_mul");
    // SPECIAL2
    issue(6'b011100, 6'b100001, e(0,0,0,1,1,4'b1000,0,0,0,0), "s2_clo");
    issue(6'b011100, 6'b100000, e(0,0,0,1,1,4'b1001,0,0,0,0), "s2_clz");
    // I-type, fcn ignored
    issue(6'b001000, 6'b100010, e(1,0,0,0,1,4'b0000,0,0,0,0), "i_addi");
    issue(6'b001101, 6'b100010, e(1,0,1,0,1,4'b0011,0,0,0,0), "i_ori");
    issue(6'b100011, 6'b100010, e(1,0,0,0,1,4'b0000,1,0,1,0), "i_lw");
    issue(6'b101011, 6'b100010, e(1,0,0,0,0,4'b0000,0,1,0,0), "i_sw");
    issue(6'b000101, 6'b100010, e(0,0,0,0,0,4'b0001,0,0,0,1), "i_bne");
    // Illegal encodings
    issue(6'b111111, 6'b100000, '0, "ill_op");
    issue(6'b000000, 6'b111111, '0, "ill_rfcn");
    issue(6'b011100, 6'b111111, '0, "ill_s2fcn");
    issue(6'b001000, 6'b000000, e(1,0,0,0,1,4'b0000,0,0,0,0), "after_ill_addi");

    waited = 0;
    while (q.size() > 0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    #1;
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d pending expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
